// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for the tile's multiply-accumulate datapath.
// A job of `len` unsigned operand pairs is pulled over a valid/ready input
// handshake. Each pair is multiplied into a one-stage product register, and the
// products are summed into an accumulator. The sum is presented over a
// valid/ready output handshake.
//
// Build option:
//   MAC_SAT_EN  defined   -> an overflowing add clamps the accumulator to all-ones
//               undefined -> an overflowing add wraps modulo 2^ACC_W
//   In both builds the sticky ovf flag is set on overflow.
module mac_seq_ctrl #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 10,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_reg;
  logic [ACC_W-1:0]      acc_reg;
  logic                  ovf_reg;
  logic [2*DATA_W-1:0]   p_reg;
  logic                  p_vld_reg;
  logic [CNT_W-1:0]      rem_reg;
  logic                  in_ready_reg;
  logic                  out_valid_reg;
  logic                  busy_reg;

  // The add is one bit wider than the accumulator so the carry out is visible.
  logic [ACC_W:0]        sum_next;
  logic                  carry_next;
  logic [ACC_W-1:0]      acc_add_next;
  logic [2*DATA_W-1:0]   prod_next;

  // Product at full 2*DATA_W width, so no bits are lost before registering.
  always_comb begin
    prod_next = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  end

  // Accumulator adder with the overflow policy chosen at build time.
  always_comb begin
    sum_next   = {1'b0, acc_reg} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, p_reg};
    carry_next = sum_next[ACC_W];
`ifdef MAC_SAT_EN
    // Once clamped, any further non-zero add carries again and re-clamps.
    acc_add_next = carry_next ? {ACC_W{1'b1}} : sum_next[ACC_W-1:0];
`else
    acc_add_next = sum_next[ACC_W-1:0];
`endif
  end

  // Sequencer FSM plus datapath registers. When ena is low, everything holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      p_reg         <= '0;
      p_vld_reg     <= 1'b0;
      rem_reg       <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        // Abort wins over start and both handshakes.
        state_reg     <= IDLE;
        acc_reg       <= '0;
        ovf_reg       <= 1'b0;
        p_vld_reg     <= 1'b0;
        rem_reg       <= '0;
        in_ready_reg  <= 1'b0;
        out_valid_reg <= 1'b0;
        busy_reg      <= 1'b0;
      end else begin
        // A pending product is folded in on every enabled edge, whatever the state.
        if (p_vld_reg) begin
          acc_reg <= acc_add_next;
          if (carry_next) begin
            ovf_reg <= 1'b1;
          end
        end
        // The product is valid for exactly one edge unless RUN accepts a new pair.
        p_vld_reg <= 1'b0;

        case (state_reg)
          IDLE: begin
            if (start) begin
              acc_reg  <= '0;
              ovf_reg  <= 1'b0;
              rem_reg  <= len;
              busy_reg <= 1'b1;
              if (len == '0) begin
                state_reg     <= DONE;
                out_valid_reg <= 1'b1;
              end else begin
                state_reg    <= RUN;
                in_ready_reg <= 1'b1;
              end
            end
          end
          RUN: begin
            if (in_valid) begin
              p_reg     <= prod_next;
              p_vld_reg <= 1'b1;
              rem_reg   <= rem_reg - CNT_W'(1);
              if (rem_reg == CNT_W'(1)) begin
                state_reg    <= DRAIN;
                in_ready_reg <= 1'b0;
              end
            end
          end
          DRAIN: begin
            // The final product is added on this edge, so the result is ready next.
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
          DONE: begin
            if (out_ready) begin
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
              busy_reg      <= 1'b0;
            end
          end
          default: begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign acc_out   = acc_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: a table of whole jobs with hand-computed
// results, followed by hand-written sequences for reset, abort, enable gating
// and the start-ignored case.
module tb_mac_seq_ctrl;

  localparam int DATA_W = 4;
  localparam int ACC_W  = 10;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .len      (len),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .ovf      (ovf),
    .busy     (busy)
  );

  // One job: pairs packed 4 bits each; pair 0 is in the least significant nibble.
  typedef struct {
    logic [3:0]  len;
    logic [19:0] pa;
    logic [19:0] pb;
    int          gap;
    int          hold;
    logic [9:0]  exp_acc;
    logic        exp_ovf;
  } job_t;

  job_t jobs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ena       = 1'b1;
    start     = 1'b0;
    len       = '0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
  endtask

  task automatic run_job(input job_t j, input int id);
    start = 1'b1;
    len   = j.len;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, (j.len != 0));
    check("start_out_valid", out_valid, (j.len == 0));
    check("start_acc_clr", acc_out, 0);
    check("start_ovf_clr", ovf, 0);
    for (int i = 0; i < int'(j.len); i++) begin
      for (int g = 0; g < j.gap; g++) begin
        in_valid = 1'b0;
        tick();
      end
      check("run_in_ready", in_ready, 1);
      in_valid = 1'b1;
      a        = j.pa[i*4 +: 4];
      b        = j.pb[i*4 +: 4];
      tick();
      in_valid = 1'b0;
    end
    if (j.len != 0) begin
      check("drain_in_ready", in_ready, 0);
      check("drain_out_valid", out_valid, 0);
      tick();
    end
    check("done_out_valid", out_valid, 1);
    check("done_acc", acc_out, j.exp_acc);
    check("done_ovf", ovf, j.exp_ovf);
    for (int h = 0; h < j.hold; h++) begin
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_acc", acc_out, j.exp_acc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consume_out_valid", out_valid, 0);
    check("consume_busy", busy, 0);
    check("idle_acc_kept", acc_out, j.exp_acc);
    $display("job %0d len=%0d acc_out=%0d ovf=%0d", id, j.len, acc_out, ovf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    jobs[0] = '{len: 4'd3, pa: {4'd0, 4'd0, 4'd1, 4'd4, 4'd2}, pb: {4'd0, 4'd0, 4'd7, 4'd5, 4'd3},
                gap: 0, hold: 0, exp_acc: 10'd33, exp_ovf: 1'b0};
    jobs[1] = '{len: 4'd0, pa: 20'd0, pb: 20'd0,
                gap: 0, hold: 0, exp_acc: 10'd0, exp_ovf: 1'b0};
    jobs[2] = '{len: 4'd2, pa: {4'd0, 4'd0, 4'd0, 4'd6, 4'd3}, pb: {4'd0, 4'd0, 4'd0, 4'd7, 4'd9},
                gap: 3, hold: 5, exp_acc: 10'd69, exp_ovf: 1'b0};
`ifdef MAC_SAT_EN
    jobs[3] = '{len: 4'd5, pa: {5{4'd15}}, pb: {5{4'd15}},
                gap: 0, hold: 1, exp_acc: 10'd1023, exp_ovf: 1'b1};
`else
    jobs[3] = '{len: 4'd5, pa: {5{4'd15}}, pb: {5{4'd15}},
                gap: 0, hold: 1, exp_acc: 10'd101, exp_ovf: 1'b1};
`endif
    jobs[4] = '{len: 4'd1, pa: {4'd0, 4'd0, 4'd0, 4'd0, 4'd15}, pb: {4'd0, 4'd0, 4'd0, 4'd0, 4'd14},
                gap: 0, hold: 0, exp_acc: 10'd210, exp_ovf: 1'b0};
    jobs[5] = '{len: 4'd4, pa: {4'd0, 4'd15, 4'd0, 4'd2, 4'd1}, pb: {4'd0, 4'd1, 4'd9, 4'd2, 4'd1},
                gap: 1, hold: 0, exp_acc: 10'd20, exp_ovf: 1'b0};

    // Reset with random inputs: all outputs low while reset is held.
    rst_n     = 1'b0;
    ena       = 1'($urandom_range(0, 1));
    start     = 1'($urandom_range(0, 1));
    len       = 4'($urandom_range(0, 15));
    clr       = 1'($urandom_range(0, 1));
    in_valid  = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
    a         = 4'($urandom_range(0, 15));
    b         = 4'($urandom_range(0, 15));
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc", acc_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    drive_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_in_ready", in_ready, 0);

    // Table-driven jobs.
    for (int k = 0; k < 6; k++) begin
      run_job(jobs[k], k);
    end

    // Abort: clr after 2 of 4 pairs, with in_valid still high.
    start = 1'b1;
    len   = 4'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a = 4'd2; b = 4'd2;
    tick();
    a = 4'd3; b = 4'd3;
    tick();
    check("pre_clr_acc", acc_out, 4);
    clr = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_in_ready", in_ready, 0);
    check("clr_out_valid", out_valid, 0);
    check("clr_acc", acc_out, 0);
    // clr beats start in IDLE.
    start = 1'b1;
    len   = 4'd2;
    clr   = 1'b1;
    tick();
    start = 1'b0;
    clr   = 1'b0;
    check("clr_over_start_busy", busy, 0);
    $display("abort via clr: busy=%0d acc_out=%0d", busy, acc_out);

    // Abort via rst_n pulsed mid-RUN: outputs clear before any clock edge.
    start = 1'b1;
    len   = 4'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a = 4'd5; b = 4'd3;
    tick();
    a = 4'd1; b = 4'd2;
    tick();
    check("pre_rst_acc", acc_out, 15);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_acc", acc_out, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("after_midrst_busy", busy, 0);
    $display("abort via rst_n: busy=%0d acc_out=%0d", busy, acc_out);

    // Enable gating mid-RUN, and start ignored during RUN.
    start = 1'b1;
    len   = 4'd3;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a = 4'd5; b = 4'd5;
    tick();
    ena = 1'b0;
    a = 4'd7; b = 4'd7;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("ena_off_in_ready", in_ready, 1);
      check("ena_off_acc", acc_out, 0);
    end
    ena = 1'b1;
    a = 4'd2; b = 4'd3;
    tick();
    check("ena_back_acc", acc_out, 25);
    check("ena_back_in_ready", in_ready, 1);
    start = 1'b1;
    len   = 4'd0;
    a = 4'd4; b = 4'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("start_ignored_in_ready", in_ready, 0);
    check("start_ignored_out_valid", out_valid, 0);
    check("start_ignored_acc", acc_out, 31);
    tick();
    check("ena_job_out_valid", out_valid, 1);
    check("ena_job_acc", acc_out, 47);
    // A consume with ena low must not take effect.
    ena       = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    check("ena_off_done_out_valid", out_valid, 1);
    check("ena_off_done_busy", busy, 1);
    ena = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ena_consume_out_valid", out_valid, 0);
    check("ena_consume_busy", busy, 0);
    check("ena_consume_acc", acc_out, 47);
    $display("enable job: acc_out=%0d ovf=%0d", acc_out, ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the tile's multiply-accumulate datapath. It accepts a job length, pulls that many unsigned operand pairs over a valid/ready handshake, and multiplies them through a one-stage product register. It sums the products into an accumulator and presents the result over a valid/ready output handshake. It sits between the `ui_in`/`uio_in` pin decode and the `uo_out` drive inside `tt_um_mac`, gated by `ena`.

## Interface

Parameters:
- `DATA_W`, default 4: operand width (unsigned).
- `ACC_W`, default 10: accumulator width; must be ≥ 2*`DATA_W`.
- `CNT_W`, default 4: job-length width; maximum job is 2^`CNT_W`-1 pairs.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: global enable; 0 freezes all state.
- `start` in 1: begin a job; honoured only in IDLE.
- `len` in `CNT_W`: number of pairs, sampled with `start`.
- `clr` in 1: synchronous abort; returns to IDLE from any state.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: pair accepted on an edge where `in_valid & in_ready & ena`.
- `a`, `b` in `DATA_W` each: operands.
- `out_valid` out 1: result available.
- `out_ready` in 1: result consumed on an edge where `out_valid & out_ready & ena`.
- `acc_out` out `ACC_W`: accumulator register.
- `ovf` out 1: sticky overflow for the current job.
- `busy` out 1: state is not IDLE.

## Operation

- States:
  - IDLE: `in_ready`=0, `out_valid`=0.
  - RUN: `in_ready`=1.
  - DRAIN: `in_ready`=0.
  - DONE: `out_valid`=1.
- IDLE with `start`=1:
  - Clear `acc`, `ovf` and `p_vld`; load `rem` from `len`.
  - Go to RUN, or to DONE if `len`=0.
- `start` in any other state is ignored.
- RUN, on each accepted pair:
  - `p` <= `a`*`b` (2*`DATA_W` bits), `p_vld` <= 1.
  - `rem` <= `rem`-1.
  - If `rem`=1, go to DRAIN.
  - With no accept, `p_vld` <= 0.
- Every enabled edge with `p_vld`=1: `acc` <= `acc` + zero-extended `p`.
- DRAIN: the final product is added; go to DONE unconditionally after one cycle.
- DONE: hold `acc_out`; on consume go to IDLE. `acc_out` keeps its value in IDLE until the next `start`.
- Overflow is the carry out of bit `ACC_W`-1 during an add. It sets `ovf`, which stays set until the next `start`. The accumulator then wraps (see Configuration).
- `clr`, when enabled:
  - Go to IDLE; clear `acc`, `p_vld`, `rem` and `ovf`.
  - `clr` has priority over `start` and over both handshakes.
- `ena`=0: no state, register or handshake update. Outputs hold, except `in_ready` and `out_valid` continue to reflect state.
- `rst_n`=0, at any time including mid-job: immediate IDLE.

## Timing

- Reset values: `in_ready`=0, `out_valid`=0, `acc_out`=0, `ovf`=0, `busy`=0. State is IDLE; `p`, `p_vld` and `rem` are 0.
- `start` edge T: `in_ready`=1 after T. For `len`=0, `out_valid`=1 after T.
- Last pair accepted at edge K: DRAIN after K, `out_valid`=1 with final `acc_out` after K+1. Latency is 2 edges.
- Throughput: one pair per cycle while `in_valid` stays high. A `len`=N job needs N+2 enabled cycles from `start` to `out_valid` with no stalls.
- Consume edge C: `out_valid`=0 and `busy`=0 after C. A new `start` is accepted at C+1 at the earliest.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration

- `MAC_SAT_EN` defined: an overflowing add clamps `acc` to 2^`ACC_W`-1, and later adds keep it there. `ovf` still sets.
- `MAC_SAT_EN` undefined: the add wraps modulo 2^`ACC_W`, and `ovf` sets.

## Test plan

- Reset: assert `rst_n`=0 with random inputs → all outputs 0, `busy`=0. After release, hold with no `start` → still IDLE.
- Basic job: `len`=3, pairs (2,3), (4,5), (1,7) streamed back-to-back → `out_valid`=1 two edges after the third accept, `acc_out`=33, `ovf`=0. After `out_ready`, back to IDLE.
- Edge cases and backpressure:
  - `len`=0 → `out_valid` the cycle after `start`, `acc_out`=0.
  - `len`=2 with `in_valid` gaps of 3 cycles and `out_ready` held low for 5 cycles → `acc_out`=product sum, stable throughout DONE.
- Overflow: `len`=5, all pairs (15,15), total 1125 with `ACC_W`=10.
  - Without `MAC_SAT_EN` → `acc_out`=101, `ovf`=1.
  - With `MAC_SAT_EN` → `acc_out`=1023, `ovf`=1.
  - Next `start` clears `ovf`.
- Abort: `clr` after 2 of 4 pairs → IDLE next edge, `acc_out`=0, `in_ready`=0. The same check with `rst_n` pulsed mid-RUN → immediate IDLE.
- Enable and priority:
  - `ena`=0 for 4 cycles mid-RUN with `in_valid`=1 → no accepts, `rem` and `acc` frozen. Result is unchanged once `ena` returns.
  - `start` asserted during RUN → ignored.
